// File: rtl/text_line_buffer.sv
// rtl/text_line_buffer.sv - single text line buffer: filtered byte intake, cursor, backspace, clear sweep
module text_line_buffer #(
   parameter int LINE_LEN = 40,
   parameter bit WRAP     = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_in_valid,
   input  logic [7:0] i_in_char,
   output logic       o_in_ready,
   input  logic       i_clear,
   output logic [7:0] o_character [0:LINE_LEN],
   output logic [5:0] o_cursor,
   output logic       o_busy,
   output logic       o_overflow
);
   localparam logic [5:0] C_FULL = 6'(LINE_LEN);
   localparam logic [5:0] C_LAST = 6'(LINE_LEN - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t     r_state;
   state_t     w_next_state;
   logic [7:0] r_char [0:LINE_LEN-1];
   logic [5:0] r_cursor;
   logic [5:0] r_idx;
   logic       r_overflow;

   logic       w_xfer;
   logic       w_printable;
   logic       w_is_bs;
   logic       w_is_cr;
   logic       w_enter_clear;
   logic [7:0] w_glyph;

   // Glyph filter: blank is stored as 0, lowercase folds onto the uppercase glyphs.
   always_comb begin
      w_printable = 1'b1;
      w_glyph     = 8'd0;
      if (((i_in_char >= 8'd48) && (i_in_char <= 8'd57)) ||
          ((i_in_char >= 8'd65) && (i_in_char <= 8'd90))) begin
         w_glyph = i_in_char;
      end else if ((i_in_char >= 8'd97) && (i_in_char <= 8'd122)) begin
         w_glyph = i_in_char - 8'd32;
      end else if (i_in_char != 8'h20) begin
         w_printable = 1'b0;
      end
      w_is_bs = (i_in_char == 8'h08);
      w_is_cr = (i_in_char == 8'h0D) || (i_in_char == 8'h0C);
   end

   assign w_xfer        = i_in_valid && o_in_ready;
   assign w_enter_clear = i_clear || (w_xfer && w_is_cr);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_enter_clear) w_next_state = S_CLEAR;
         S_CLEAR: if (r_idx == C_LAST) w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      o_in_ready = (r_state == S_IDLE) && !i_clear && !i_rst;
      o_busy     = (r_state == S_CLEAR);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < LINE_LEN; i++) r_char[i] <= 8'd0;
         r_cursor   <= 6'd0;
         r_idx      <= 6'd0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_enter_clear) begin
                  r_idx <= 6'd0;
               end else if (w_xfer) begin
                  if (w_printable) begin
                     if (r_cursor != C_FULL) begin
                        r_char[r_cursor] <= w_glyph;
                        r_cursor         <= r_cursor + 6'd1;
                     end else if (WRAP) begin
                        r_char[0] <= w_glyph;
                        r_cursor  <= 6'd1;
                     end else begin
                        r_overflow <= 1'b1;
                     end
                  end else if (w_is_bs && (r_cursor != 6'd0)) begin
                     r_cursor                 <= r_cursor - 6'd1;
                     r_char[r_cursor - 6'd1]  <= 8'd0;
                  end
               end
            end
            S_CLEAR: begin
               r_char[r_idx] <= 8'd0;
               r_idx         <= r_idx + 6'd1;
               if (r_idx == C_LAST) begin
                  r_cursor   <= 6'd0;
                  r_overflow <= 1'b0;
               end
            end
         endcase
      end
   end

   // The trailing slot is a fixed terminator for the renderer.
   always_comb begin
      for (int i = 0; i < LINE_LEN; i++) o_character[i] = r_char[i];
      o_character[LINE_LEN] = 8'd0;
   end

   assign o_cursor   = r_cursor;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_text_line_buffer.sv
// tb/tb_text_line_buffer.sv - randomized self-checking bench for text_line_buffer (WRAP=0 and WRAP=1 side by side)
module tb_text_line_buffer;
   localparam int LEN = 40;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_char;
   logic       clear;
   logic       rdy0, rdy1, busy0, busy1, ovf0, ovf1;
   logic [5:0] cur0, cur1;
   logic [7:0] ch0 [0:LEN];
   logic [7:0] ch1 [0:LEN];

   int checks = 0;
   int errors = 0;

   // Reference line model, one per WRAP setting; index 0 is WRAP=0.
   int m_char [2][LEN+1];
   int m_cur  [2];
   bit m_ovf  [2];
   int m_busy;

   always #5 clk = ~clk;

   text_line_buffer #(.LINE_LEN(LEN), .WRAP(1'b0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_char(in_char),
      .o_in_ready(rdy0), .i_clear(clear), .o_character(ch0), .o_cursor(cur0),
      .o_busy(busy0), .o_overflow(ovf0));

   text_line_buffer #(.LINE_LEN(LEN), .WRAP(1'b1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_char(in_char),
      .o_in_ready(rdy1), .i_clear(clear), .o_character(ch1), .o_cursor(cur1),
      .o_busy(busy1), .o_overflow(ovf1));

   task automatic model_reset();
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i <= LEN; i++) m_char[w][i] = 0;
         m_cur[w] = 0;
         m_ovf[w] = 1'b0;
      end
      m_busy = 0;
   endtask

   task automatic model_edge(input bit v, input logic [7:0] c, input bit clr);
      int  ci;
      int  g;
      bit  pr;
      ci = int'(c);
      if (m_busy > 0) begin
         for (int w = 0; w < 2; w++) m_char[w][LEN - m_busy] = 0;
         m_busy--;
         if (m_busy == 0) begin
            for (int w = 0; w < 2; w++) begin
               m_cur[w] = 0;
               m_ovf[w] = 1'b0;
            end
         end
      end else if (clr) begin
         m_busy = LEN;
      end else if (v) begin
         pr = 1'b1;
         g  = 0;
         if ((ci >= 48 && ci <= 57) || (ci >= 65 && ci <= 90)) g = ci;
         else if (ci >= 97 && ci <= 122) g = ci - 32;
         else if (ci != 32) pr = 1'b0;
         if (pr) begin
            for (int w = 0; w < 2; w++) begin
               if (m_cur[w] < LEN) begin
                  m_char[w][m_cur[w]] = g;
                  m_cur[w]++;
               end else if (w == 1) begin
                  m_char[w][0] = g;
                  m_cur[w]     = 1;
               end else begin
                  m_ovf[w] = 1'b1;
               end
            end
         end else if (ci == 8) begin
            for (int w = 0; w < 2; w++) begin
               if (m_cur[w] > 0) begin
                  m_cur[w]--;
                  m_char[w][m_cur[w]] = 0;
               end
            end
         end else if (ci == 13 || ci == 12) begin
            m_busy = LEN;
         end
      end
   endtask

   // One clock: drive inputs, check handshake/busy before the edge, advance the model.
   task automatic cycle(input bit v, input logic [7:0] c, input bit clr);
      bit exp_rdy;
      in_valid = v;
      in_char  = c;
      clear    = clr;
      #1;
      exp_rdy = (m_busy == 0) && !clr;
      checks++;
      if (rdy0 !== exp_rdy || rdy1 !== exp_rdy) begin
         errors++;
         $display("FAIL in_ready: got %b/%b expected %b (char %h clear %b)", rdy0, rdy1, exp_rdy, c, clr);
      end
      checks++;
      if (busy0 !== (m_busy != 0) || busy1 !== (m_busy != 0)) begin
         errors++;
         $display("FAIL busy: got %b/%b expected %b", busy0, busy1, (m_busy != 0));
      end
      @(posedge clk);
      model_edge(v, c, clr);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1; in_valid = 1'b1; in_char = 8'd65; clear = 1'b0;
      #1;
      checks++;
      if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b/%b expected 0", rdy0, rdy1);
      end
      checks++;
      if (cur0 !== 6'd0 || busy0 !== 1'b0 || ovf0 !== 1'b0 || cur1 !== 6'd0) begin
         errors++; $display("FAIL reset_state: cursor %0d busy %b overflow %b expected 0 0 0", cur0, busy0, ovf0);
      end
      bad = -1;
      for (int i = 0; i <= LEN; i++) if (ch0[i] !== 8'd0 || ch1[i] !== 8'd0) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++; $display("FAIL reset_slots: slot %0d got %0d expected 0", bad, ch0[bad]);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      model_reset();
   endtask

   task automatic test_basic();
      do_reset();
      cycle(1'b1, 8'd65, 1'b0);
      cycle(1'b1, 8'd66, 1'b0);
      cycle(1'b1, 8'd55, 1'b0);
      checks++;
      if (ch0[0] !== 8'd65 || ch0[1] !== 8'd66 || ch0[2] !== 8'd55 || ch0[3] !== 8'd0) begin
         errors++; $display("FAIL basic_slots: got %0d %0d %0d %0d expected 65 66 55 0", ch0[0], ch0[1], ch0[2], ch0[3]);
      end
      checks++;
      if (cur0 !== 6'd3 || cur1 !== 6'd3) begin
         errors++; $display("FAIL basic_cursor: got %0d/%0d expected 3", cur0, cur1);
      end
   endtask

   task automatic test_case_fold();
      do_reset();
      cycle(1'b1, 8'd113, 1'b0);
      cycle(1'b1, 8'd122, 1'b0);
      cycle(1'b1, 8'h20,  1'b0);
      cycle(1'b1, 8'h21,  1'b0);
      checks++;
      if (ch0[0] !== 8'd81 || ch0[1] !== 8'd90 || ch0[2] !== 8'd0 || ch0[3] !== 8'd0) begin
         errors++; $display("FAIL fold_slots: got %0d %0d %0d %0d expected 81 90 0 0", ch0[0], ch0[1], ch0[2], ch0[3]);
      end
      checks++;
      if (cur0 !== 6'd3) begin
         errors++; $display("FAIL fold_cursor: got %0d expected 3", cur0);
      end
   endtask

   task automatic test_backspace();
      int exp_cur [3] = '{1, 0, 0};
      do_reset();
      cycle(1'b1, 8'd65, 1'b0);
      cycle(1'b1, 8'd66, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 8'h08, 1'b0);
         checks++;
         if (cur0 !== 6'(exp_cur[k]) || cur1 !== 6'(exp_cur[k])) begin
            errors++; $display("FAIL bs_cursor[%0d]: got %0d/%0d expected %0d", k, cur0, cur1, exp_cur[k]);
         end
      end
      checks++;
      if (ch0[0] !== 8'd0 || ch0[1] !== 8'd0) begin
         errors++; $display("FAIL bs_slots: got %0d %0d expected 0 0", ch0[0], ch0[1]);
      end
   endtask

   task automatic test_full_line();
      do_reset();
      repeat (LEN + 1) cycle(1'b1, 8'd65, 1'b0);
      checks++;
      if (cur0 !== 6'd40 || ovf0 !== 1'b1) begin
         errors++; $display("FAIL nowrap_full: cursor %0d overflow %b expected 40 1", cur0, ovf0);
      end
      checks++;
      if (cur1 !== 6'd1 || ch1[0] !== 8'd65 || ovf1 !== 1'b0) begin
         errors++; $display("FAIL wrap_full: cursor %0d slot0 %0d overflow %b expected 1 65 0", cur1, ch1[0], ovf1);
      end
      checks++;
      if (ch0[39] !== 8'd65 || ch0[LEN] !== 8'd0) begin
         errors++; $display("FAIL full_slots: slot39 %0d slot40 %0d expected 65 0", ch0[39], ch0[LEN]);
      end
      in_valid = 1'b1; in_char = 8'd65;
      #1;
      checks++;
      if (rdy0 !== 1'b1) begin
         errors++; $display("FAIL full_ready: got %b expected 1", rdy0);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_clear();
      int n;
      int bad;
      cycle(1'b1, 8'd66, 1'b1);
      n = 0;
      while (busy0 === 1'b1 && n < 60) begin
         cycle(1'b1, 8'd88, 1'b0);
         n++;
      end
      checks++;
      if (n != LEN) begin
         errors++; $display("FAIL clear_duration: got %0d busy cycles expected %0d", n, LEN);
      end
      bad = -1;
      for (int i = 0; i <= LEN; i++) if (ch0[i] !== 8'd0 || ch1[i] !== 8'd0) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++; $display("FAIL clear_slots: slot %0d got %0d/%0d expected 0", bad, ch0[bad], ch1[bad]);
      end
      checks++;
      if (cur0 !== 6'd0 || cur1 !== 6'd0 || ovf0 !== 1'b0) begin
         errors++; $display("FAIL clear_state: cursor %0d/%0d overflow %b expected 0 0 0", cur0, cur1, ovf0);
      end
   endtask

   task automatic test_reset_mid_clear();
      int bad;
      do_reset();
      cycle(1'b1, 8'd72, 1'b0);
      cycle(1'b1, 8'd73, 1'b0);
      cycle(1'b0, 8'd0, 1'b1);
      repeat (10) cycle(1'b0, 8'd0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      bad = -1;
      for (int i = 0; i <= LEN; i++) if (ch0[i] !== 8'd0) bad = i;
      checks++;
      if (bad >= 0 || busy0 !== 1'b0 || cur0 !== 6'd0 || ovf0 !== 1'b0 || rdy0 !== 1'b0) begin
         errors++; $display("FAIL async_reset: busy %b cursor %0d ready %b bad slot %0d expected 0 0 0 -1", busy0, cur0, rdy0, bad);
      end
      #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      cycle(1'b1, 8'd53, 1'b0);
      checks++;
      if (ch0[0] !== 8'd53 || cur0 !== 6'd1) begin
         errors++; $display("FAIL after_reset_send: slot0 %0d cursor %0d expected 53 1", ch0[0], cur0);
      end
   endtask

   task automatic test_random();
      logic [7:0] c;
      bit         v;
      bit         clr;
      int         r;
      int         bad;
      do_reset();
      for (int it = 0; it < 500; it++) begin
         r   = int'($urandom_range(0, 9));
         case (r)
            0, 1, 2: c = 8'($urandom_range(65, 90));
            3:       c = 8'($urandom_range(97, 122));
            4:       c = 8'($urandom_range(48, 57));
            5:       c = 8'h20;
            6:       c = 8'h08;
            7:       c = ($urandom_range(0, 9) == 0) ? 8'h0D : 8'h2E;
            default: c = 8'($urandom_range(0, 255));
         endcase
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 149) == 0);
         cycle(v, c, clr);
         checks++;
         if (cur0 !== 6'(m_cur[0]) || cur1 !== 6'(m_cur[1]) || ovf0 !== m_ovf[0] || ovf1 !== m_ovf[1]) begin
            errors++;
            $display("FAIL rand_state[%0d]: cursor %0d/%0d overflow %b/%b expected %0d/%0d %b/%b",
                     it, cur0, cur1, ovf0, ovf1, m_cur[0], m_cur[1], m_ovf[0], m_ovf[1]);
         end
         bad = -1;
         for (int i = 0; i <= LEN; i++)
            if (ch0[i] !== 8'(m_char[0][i]) || ch1[i] !== 8'(m_char[1][i])) bad = i;
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL rand_slots[%0d]: slot %0d got %0d/%0d expected %0d/%0d",
                     it, bad, ch0[bad], ch1[bad], m_char[0][bad], m_char[1][bad]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_char = 8'd0; clear = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_case_fold();
      test_backspace();
      test_full_line();
      test_clear();
      test_reset_mid_clear();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
